// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Purpose  : Byte-serial fetch from a synchronous instruction memory. Bytes are
//            assembled into little-endian words and queued for decode.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int DWIDTH     = 8,
    parameter int ADDR       = 10,
    parameter int INST_BYTES = 4,
    parameter int DEPTH      = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [ADDR-1:0]              i_start_pc,
    input  logic                         i_redirect,
    input  logic [ADDR-1:0]              i_redirect_pc,
    input  logic                         i_halt,
    output logic                         o_mem_csb,
    output logic                         o_mem_web,
    output logic [ADDR-1:0]              o_mem_addr,
    input  logic [DWIDTH-1:0]            i_mem_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DWIDTH*INST_BYTES-1:0] o_inst,
    output logic [ADDR-1:0]              o_pc,
    output logic                         o_busy
);

    localparam int              c_iw    = DWIDTH * INST_BYTES;
    localparam int              c_pw    = $clog2(DEPTH);
    localparam int              c_cw    = $clog2(DEPTH) + 2;
    localparam logic [ADDR-1:0] c_low   = ADDR'(INST_BYTES - 1);
    localparam logic [ADDR-1:0] c_align = ~c_low;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR-1:0]   r_pc;
    logic [ADDR-1:0]   r_mem_addr;
    logic              r_mem_csb;
    logic              r_tag_a;
    logic              r_tag_b;
    logic [ADDR-1:0]   r_addr_b;
    logic [c_cw-1:0]   r_asm_words;
    logic [DWIDTH-1:0] r_slot [INST_BYTES-1];

    logic [c_iw-1:0]   r_fifo_inst [DEPTH];
    logic [ADDR-1:0]   r_fifo_pc   [DEPTH];
    logic [c_pw-1:0]   r_wr_ptr;
    logic [c_pw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;

    logic              w_can_begin;
    logic              w_issue;
    logic              w_begin;
    logic [ADDR-1:0]   w_issue_pc;
    logic              w_push;
    logic              w_pop;
    logic [c_iw-1:0]   w_word;
    logic [ADDR-1:0]   w_push_pc;

    // Slots are reserved at word start, so a push can never find the FIFO full.
    assign w_can_begin = ((r_count + r_asm_words) < c_cw'(DEPTH)) && !i_halt;

    always_comb begin
        w_issue_pc = r_pc;
        w_issue    = 1'b0;
        if (r_state == S_IDLE) begin
            w_issue_pc = i_start_pc & c_align;
            w_issue    = i_start;
        end else begin
            w_issue = ((r_pc & c_low) != '0) || w_can_begin;
        end
    end

    assign w_begin   = w_issue && ((w_issue_pc & c_low) == '0);
    assign w_push    = r_tag_b && ((r_addr_b & c_low) == c_low);
    assign w_push_pc = r_addr_b - c_low;
    assign w_pop     = o_valid && i_ready;

    for (genvar k = 0; k < INST_BYTES - 1; k++) begin : g_word
        assign w_word[k*DWIDTH +: DWIDTH] = r_slot[k];
    end
    assign w_word[c_iw-1 -: DWIDTH] = i_mem_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_mem_addr  <= '0;
            r_mem_csb   <= 1'b1;
            r_tag_a     <= 1'b0;
            r_tag_b     <= 1'b0;
            r_addr_b    <= '0;
            r_asm_words <= '0;
            for (int k = 0; k < INST_BYTES - 1; k++) r_slot[k] <= '0;
        end else if (i_redirect) begin
            r_state     <= S_ISSUE;
            r_pc        <= i_redirect_pc & c_align;
            r_mem_csb   <= 1'b1;
            r_tag_a     <= 1'b0;
            r_tag_b     <= 1'b0;
            r_asm_words <= '0;
        end else begin
            // Byte index within a word is the low address bits, since words are aligned.
            r_tag_b  <= r_tag_a;
            r_addr_b <= r_mem_addr;
            for (int k = 0; k < INST_BYTES - 1; k++) begin
                if (r_tag_b && ((r_addr_b & c_low) == ADDR'(k))) r_slot[k] <= i_mem_data;
            end
            r_mem_csb   <= ~w_issue;
            r_tag_a     <= w_issue;
            r_asm_words <= r_asm_words + c_cw'(w_begin) - c_cw'(w_push);
            if (w_issue) begin
                r_state    <= S_ISSUE;
                r_mem_addr <= w_issue_pc;
                r_pc       <= w_issue_pc + ADDR'(1);
            end else if (r_state != S_IDLE) begin
                r_state <= S_STALL;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_inst[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (i_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_inst[r_wr_ptr] <= w_word;
                r_fifo_pc[r_wr_ptr]   <= w_push_pc;
                r_wr_ptr              <= r_wr_ptr + c_pw'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_pw'(1);
            r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
        end
    end

    assign o_mem_csb  = r_mem_csb;
    assign o_mem_web  = 1'b1;
    assign o_mem_addr = r_mem_addr;
    assign o_valid    = (r_count != '0);
    assign o_inst     = r_fifo_inst[r_rd_ptr];
    assign o_pc       = r_fifo_pc[r_rd_ptr];
    assign o_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_unit
// Purpose  : Directed self-checking bench for inst_fetch_unit with a
//            synchronous byte-memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam int DWIDTH     = 8;
    localparam int ADDR       = 10;
    localparam int INST_BYTES = 4;
    localparam int DEPTH      = 2;
    localparam int c_iw       = DWIDTH * INST_BYTES;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic [ADDR-1:0]   i_start_pc;
    logic              i_redirect;
    logic [ADDR-1:0]   i_redirect_pc;
    logic              i_halt;
    logic              o_mem_csb;
    logic              o_mem_web;
    logic [ADDR-1:0]   o_mem_addr;
    logic [DWIDTH-1:0] i_mem_data;
    logic              o_valid;
    logic              i_ready;
    logic [c_iw-1:0]   o_inst;
    logic [ADDR-1:0]   o_pc;
    logic              o_busy;

    logic [DWIDTH-1:0] mem [1 << ADDR];
    int                n_vec = 0;
    int                n_err = 0;
    int                n_issued = 0;
    logic [ADDR+c_iw-1:0] words [$];

    always #5 i_clk = ~i_clk;

    inst_fetch_unit #(
        .DWIDTH    (DWIDTH),
        .ADDR      (ADDR),
        .INST_BYTES(INST_BYTES),
        .DEPTH     (DEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_start_pc   (i_start_pc),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .i_halt       (i_halt),
        .o_mem_csb    (o_mem_csb),
        .o_mem_web    (o_mem_web),
        .o_mem_addr   (o_mem_addr),
        .i_mem_data   (i_mem_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_busy       (o_busy)
    );

    // Synchronous read: address sampled on the edge, data valid after it.
    always @(posedge i_clk) begin
        if (!o_mem_csb) i_mem_data <= mem[o_mem_addr];
    end

    always @(negedge i_clk) begin
        if (!o_mem_csb) n_issued++;
        if (o_valid && i_ready) words.push_back({o_pc, o_inst});
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_redirect = 1'b0;
        i_halt     = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        tick();
    endtask

    task automatic start(input logic [ADDR-1:0] pc);
        i_start_pc = pc;
        i_start    = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int need);
        int n = 0;
        while (words.size() < need && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(words.size() >= need), 64'd1);
    endtask

    task automatic wait_issue(input string tag, output logic [ADDR-1:0] addr);
        int n = 0;
        while (o_mem_csb && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 64'(o_mem_csb), 64'd0);
        addr = o_mem_addr;
    endtask

    function automatic logic [ADDR+c_iw-1:0] word_at(input int idx);
        if (idx < words.size()) return words[idx];
        return '1;
    endfunction

    initial begin : main
        logic [ADDR-1:0] av;
        logic [ADDR-1:0] nxt;
        int              base;
        int              iss;
        int              lat;
        int              nvalid;

        for (int a = 0; a < (1 << ADDR); a++) begin
            av     = ADDR'(a);
            mem[a] = av[7:0] ^ {av[9:8], 6'b0};
        end
        i_ready       = 1'b1;
        i_start_pc    = '0;
        i_redirect_pc = '0;

        // Reset state
        i_rst = 1'b1; i_start = 1'b0; i_redirect = 1'b0; i_halt = 1'b0;
        tick();
        chk("rst_csb",   64'(o_mem_csb),  64'd1);
        chk("rst_web",   64'(o_mem_web),  64'd1);
        chk("rst_addr",  64'(o_mem_addr), 64'd0);
        chk("rst_valid", 64'(o_valid),    64'd0);
        chk("rst_inst",  64'(o_inst),     64'd0);
        chk("rst_pc",    64'(o_pc),       64'd0);
        chk("rst_busy",  64'(o_busy),     64'd0);

        // Streaming fetch from 0
        do_reset();
        base = words.size();
        start(10'h000);
        chk("t1_csb",  64'(o_mem_csb),  64'd0);
        chk("t1_addr", 64'(o_mem_addr), 64'd0);
        chk("t1_busy", 64'(o_busy),     64'd1);
        lat = 0;
        while (!o_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("t1_latency", 64'(lat), 64'd5);
        wait_words("t1_words", base + 3);
        chk("t1_w0", 64'(word_at(base)),     64'({10'h000, 32'h03020100}));
        chk("t1_w1", 64'(word_at(base + 1)), 64'({10'h004, 32'h07060504}));
        chk("t1_w2", 64'(word_at(base + 2)), 64'({10'h008, 32'h0B0A0908}));

        // Backpressure fills the FIFO, then issue resumes at 8
        do_reset();
        i_ready = 1'b0;
        base = words.size();
        iss  = n_issued;
        start(10'h000);
        repeat (20) tick();
        chk("t2_valid",  64'(o_valid),        64'd1);
        chk("t2_inst",   64'(o_inst),         64'h03020100);
        chk("t2_pc",     64'(o_pc),           64'd0);
        chk("t2_csb",    64'(o_mem_csb),      64'd1);
        chk("t2_addr",   64'(o_mem_addr),     64'd7);
        chk("t2_issued", 64'(n_issued - iss), 64'd8);
        i_ready = 1'b1;
        wait_issue("t2_resume", nxt);
        chk("t2_next_addr", 64'(nxt), 64'd8);
        wait_words("t2_words", base + 2);
        chk("t2_w0", 64'(word_at(base)),     64'({10'h000, 32'h03020100}));
        chk("t2_w1", 64'(word_at(base + 1)), 64'({10'h004, 32'h07060504}));

        // Redirect mid-word, with wrap past the top of memory
        do_reset();
        base = words.size();
        start(10'h000);
        tick();
        i_redirect_pc = 10'h3FE;
        i_redirect    = 1'b1;
        tick();
        i_redirect = 1'b0;
        wait_words("t3_words", base + 2);
        chk("t3_w0", 64'(word_at(base)),     64'({10'h3FC, 32'h3F3E3D3C}));
        chk("t3_w1", 64'(word_at(base + 1)), 64'({10'h000, 32'h03020100}));

        // Unaligned start
        do_reset();
        base = words.size();
        start(10'h006);
        wait_words("t4_words", base + 1);
        chk("t4_w0", 64'(word_at(base)), 64'({10'h004, 32'h07060504}));

        // Reset while the third byte is in flight
        do_reset();
        base = words.size();
        start(10'h000);
        tick();
        tick();
        i_rst = 1'b1;
        #1;
        chk("t5_csb",   64'(o_mem_csb),  64'd1);
        chk("t5_addr",  64'(o_mem_addr), 64'd0);
        chk("t5_valid", 64'(o_valid),    64'd0);
        chk("t5_busy",  64'(o_busy),     64'd0);
        tick();
        i_rst  = 1'b0;
        nvalid = 0;
        repeat (12) begin
            tick();
            if (o_valid) nvalid++;
        end
        chk("t5_no_valid", 64'(nvalid), 64'd0);
        chk("t5_no_words", 64'(words.size() - base), 64'd0);
        start(10'h000);
        wait_words("t5_words", base + 1);
        chk("t5_w0", 64'(word_at(base)), 64'({10'h000, 32'h03020100}));

        // Halt after the second address of a word
        do_reset();
        base = words.size();
        iss  = n_issued;
        start(10'h000);
        tick();
        i_halt = 1'b1;
        repeat (15) tick();
        chk("t6_issued", 64'(n_issued - iss),     64'd4);
        chk("t6_words",  64'(words.size() - base), 64'd1);
        chk("t6_csb",    64'(o_mem_csb),           64'd1);
        chk("t6_busy",   64'(o_busy),              64'd1);
        chk("t6_w0",     64'(word_at(base)),       64'({10'h000, 32'h03020100}));
        i_halt = 1'b0;
        wait_issue("t6_resume", nxt);
        chk("t6_next_addr", 64'(nxt), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly downstream of the byte-wide instruction memory (8-bit data, 10-bit address, active-low chip select and write enable).
- Drives the memory read port, issuing one byte read per cycle from a program counter.
- Assembles little-endian 32-bit instruction words and buffers them in a small FIFO.
- Presents each word with its PC to decode over a valid/ready handshake. Supports start and redirect (flush) from the core.

Parameters:
- DWIDTH, 8: memory data width in bits.
- ADDR, 10: memory address width in bits; the PC is ADDR bits, byte-addressed.
- INST_BYTES, 4: bytes per instruction. The instruction width is DWIDTH*INST_BYTES.
- DEPTH, 2: output FIFO entries (power of 2, ≥2).

Ports:
- i_clk  in  1  clock, shared with the memory.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  one-cycle pulse; begin fetching at i_start_pc.
- i_start_pc  in  ADDR  start byte address.
- i_redirect  in  1  one-cycle pulse; flush and refetch from i_redirect_pc.
- i_redirect_pc  in  ADDR  redirect byte address.
- i_halt  in  1  level; stop issuing new words while high.
- o_mem_csb  out  1  memory chip select, active low.
- o_mem_web  out  1  memory write enable, active low; constant 1.
- o_mem_addr  out  ADDR  memory read address.
- i_mem_data  in  DWIDTH  memory read data, valid 1 cycle after the address edge.
- o_valid  out  1  instruction available.
- i_ready  in  1  decode accepts.
- o_inst  out  DWIDTH*INST_BYTES  instruction word; byte 0 in bits [7:0].
- o_pc  out  ADDR  address of byte 0 of o_inst.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:

Reset (async, i_rst=1):
- o_mem_csb=1, o_mem_web=1, o_mem_addr=0, o_valid=0, o_inst=0, o_pc=0, o_busy=0.
- FIFO empty, state IDLE, PC=0.

Outputs:
- All memory-side outputs are registered.

Alignment and wrap:
- Start and redirect PCs have their low log2(INST_BYTES) bits forced to 0.
- PC increments modulo 2^ADDR: after byte 1023 comes 0.

Read timing:
- Address A is presented after edge E, the memory samples it at E+1, and the byte is captured at E+2.
- A one-bit in-flight tag marks each issued read. Returns whose tag is cleared are discarded.

State machine:
- IDLE: csb=1. i_start → ISSUE with PC=i_start_pc.
- ISSUE: csb=0, addr=PC, PC+=1 each cycle.
  - A new word may begin only if fifo_count + words_in_assembly < DEPTH and i_halt=0.
  - Once begun, all INST_BYTES reads of a word are issued back-to-back.
  - If a new word cannot begin → STALL.
- STALL: csb=1, no issue. Return to ISSUE when the condition above holds.

Assembly and push:
- Byte k of a word is written into shift-register slot k.
- When the last byte is captured, {word, word_pc} is pushed into the FIFO on that same edge.

Latency:
- With i_start sampled at E0, the addresses appear after E0..E3.
- o_valid rises after E5.
- Steady-state throughput is one word per INST_BYTES cycles.

Handshake:
- The FIFO head drives o_inst/o_pc.
- Pop occurs when o_valid&i_ready.
- o_inst/o_pc stay stable while o_valid=1 and i_ready=0.
- A simultaneous push and pop on a full FIFO is legal only because slots are reserved, so no overflow can occur.

Redirect (priority over start, halt and push):
- On the edge where i_redirect=1: FIFO cleared, partial word dropped, all in-flight tags cleared, o_valid=0 next cycle.
- Next cycle: ISSUE with PC=i_redirect_pc.
- A pop coincident with a redirect is still counted as consumed.

i_start while not IDLE:
- Ignored.

i_halt:
- Finishes the current word.
- Then STALL; on exit the PC continues from where it stopped.
- Returns to IDLE only via reset.

Reset mid-word:
- All state is cleared immediately.
- Any byte returned afterwards is ignored because its tags are cleared.

Test Plan:
- Memory preloaded with bytes 0x00..0x0F at addresses 0..15; start pc=0, i_ready=1 → o_inst=0x03020100 (pc 0), then 0x07060504 (pc 4), 0x0B0A0908 (pc 8); first o_valid 5 edges after start.
- Same preload, i_ready=0 → exactly 2 words buffered; addresses stop at 7 with csb=1; o_inst holds 0x03020100; raising i_ready resumes issue at address 8.
- Redirect to pc 0x3FE (aligned to 0x3FC) mid-word after start pc=0 → the first word delivered has pc 0x3FC with bytes from 0x3FC..0x3FF; the next has pc 0 (wrap); no partial or stale bytes are delivered.
- Start pc=0x006 → aligned to 4; first o_pc=4, o_inst=0x07060504.
- Assert i_rst for 1 cycle while the 3rd byte of a word is in flight → outputs at reset values; no o_valid until a new start; subsequent fetch from pc 0 is correct.
- i_halt raised after the 2nd address of a word → exactly one word completes; csb stays high while halted; release → next address = word_pc+4.
